hram_uart_host: RTL and testbench



---
 rtl/hram_cmd_pkg.sv | 49 ++++
 rtl/hram_uart_tx_seq.sv | 70 +++++++
 rtl/hram_uart_host.sv | 157 +++++++++++++++
 tb/tb_hram_uart_host.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hram_cmd_pkg.sv
// Shared definitions for the HyperRAM serial debug protocol: opcodes, frame
// sizes, fixed reply constants and the state encodings of the host side.
package hram_cmd_pkg;

    localparam logic [7:0] OP_ADDR     = 8'd1;
    localparam logic [7:0] OP_LOAD     = 8'd2;
    localparam logic [7:0] OP_WRITE    = 8'd3;
    localparam logic [7:0] OP_READ     = 8'd4;
    localparam logic [7:0] OP_READ_REQ = 8'd5;
    localparam logic [7:0] OP_COUNT    = 8'd6;
    localparam logic [7:0] OP_CONST    = 8'd7;

    localparam int FRAME_TX_BYTES = 6;
    localparam int FRAME_RX_BYTES = 5;

    localparam logic [31:0] CONST_VALUE  = 32'd259;
    localparam logic [31:0] WRITE_ACK    = 32'd3;
    localparam logic [31:0] READ_REQ_ACK = 32'd5;
    localparam logic [7:0]  PAD_BYTE     = 8'h00;

    typedef enum logic [1:0] {
        HOST_IDLE,
        HOST_TX,
        HOST_RX_WAIT,
        HOST_DONE
    } host_state_e;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_BYTE,
        SEQ_WAIT
    } seq_state_e;

    // Byte idx of a 6-byte frame, byte 0 being the most significant (sent first).
    function automatic logic [7:0] frame_byte(input logic [47:0] frame, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = frame[47:40];
            3'd1:    b = frame[39:32];
            3'd2:    b = frame[31:24];
            3'd3:    b = frame[23:16];
            3'd4:    b = frame[15:8];
            3'd5:    b = frame[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/hram_uart_tx_seq.sv
// Byte-level start/ready handshake towards uart_tx. Walks the six bytes of a
// latched frame, holding tx_start until uart_tx drops ready (it may take up
// to two cycles), then waiting for ready to return before the next byte.
module hram_uart_tx_seq
    import hram_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [47:0] frame,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        done
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_TX_BYTES - 1);

    seq_state_e state_q, state_d;
    logic [2:0] tx_idx_q, tx_idx_d;

    // State and byte index registers; reset drops tx_start immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= SEQ_IDLE;
            tx_idx_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            tx_idx_q <= tx_idx_d;
        end
    end

    // Handshake sequencing: start held in SEQ_BYTE, release waited in SEQ_WAIT.
    always_comb begin
        state_d  = state_q;
        tx_idx_d = tx_idx_q;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        done     = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    tx_idx_d = 3'd0;
                    state_d  = SEQ_BYTE;
                end
            end
            SEQ_BYTE: begin
                tx_start = 1'b1;
                tx_data  = frame_byte(frame, tx_idx_q);
                if (!tx_ready) begin
                    state_d = SEQ_WAIT;
                end
            end
            SEQ_WAIT: begin
                tx_data = frame_byte(frame, tx_idx_q);
                if (tx_ready) begin
                    if (tx_idx_q == LAST_IDX) begin
                        done    = 1'b1;
                        state_d = SEQ_IDLE;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        state_d  = SEQ_BYTE;
                    end
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

endmodule

// File: rtl/hram_uart_host.sv
// Host-side command initiator for the HyperRAM serial debug protocol.
// Sends {op, operand[31:0], TRAILER} through uart_tx, collects the 5-byte
// reply from uart_rx and returns the first four bytes with status.
// Optional macro HRAM_UART_HOST_RSP_CHECK_EN enables the echo/pad compare
// that drives rsp_mismatch; without it rsp_mismatch is tied low.
// A frame abandoned by reset leaves the responder's byte counter out of step;
// only an external reset of the responder brings it back.
module hram_uart_host
    import hram_cmd_pkg::*;
#(
    parameter logic [7:0] TRAILER        = 8'h0A,
    parameter int         TIMEOUT_CYCLES = 1_200_000,
    parameter int         TO_W           = 21
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        rsp_mismatch,
    output logic        busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_rcv,
    input  logic [7:0]  rx_data
);

    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES);
    localparam logic [2:0]      LAST_RX = 3'(FRAME_RX_BYTES - 1);

    host_state_e     state_q, state_d;
    logic [47:0]     frame_q, frame_d;
    logic [39:0]     reply_q, reply_d;
    logic [2:0]      rx_idx_q, rx_idx_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
    logic            seq_start;
    logic            seq_done;

    assign seq_start = (state_q == HOST_IDLE) && cmd_valid;

    hram_uart_tx_seq u_tx_seq (
        .clk      (clk),
        .rstn     (rstn),
        .start    (seq_start),
        .frame    (frame_q),
        .tx_ready (tx_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .done     (seq_done)
    );

    // Frame, reply and timeout registers of the command FSM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= HOST_IDLE;
            frame_q   <= '0;
            reply_q   <= '0;
            rx_idx_q  <= 3'd0;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            reply_q   <= reply_d;
            rx_idx_q  <= rx_idx_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Command FSM: accept, transmit, gather reply bytes left-aligned, report.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        reply_d   = reply_q;
        rx_idx_d  = rx_idx_q;
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            HOST_IDLE: begin
                if (cmd_valid) begin
                    frame_d   = {cmd_op, cmd_data, TRAILER};
                    reply_d   = '0;
                    rx_idx_d  = 3'd0;
                    to_cnt_d  = '0;
                    timeout_d = 1'b0;
                    state_d   = HOST_TX;
                end
            end
            HOST_TX: begin
                if (seq_done) begin
                    to_cnt_d = TO_LOAD;
                    state_d  = HOST_RX_WAIT;
                end
            end
            HOST_RX_WAIT: begin
                if (rx_rcv) begin
                    case (rx_idx_q)
                        3'd0:    reply_d[39:32] = rx_data;
                        3'd1:    reply_d[31:24] = rx_data;
                        3'd2:    reply_d[23:16] = rx_data;
                        3'd3:    reply_d[15:8]  = rx_data;
                        3'd4:    reply_d[7:0]   = rx_data;
                        default: reply_d        = reply_q;
                    endcase
                    rx_idx_d = rx_idx_q + 3'd1;
                    to_cnt_d = TO_LOAD;
                    if (rx_idx_q == LAST_RX) begin
                        state_d = HOST_DONE;
                    end
                end else if (to_cnt_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = HOST_DONE;
                end else begin
                    to_cnt_d = to_cnt_q - TO_W'(1);
                end
            end
            HOST_DONE: begin
                state_d = HOST_IDLE;
            end
            default: state_d = HOST_IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == HOST_IDLE);
    assign busy        = (state_q != HOST_IDLE);
    assign rsp_valid   = (state_q == HOST_DONE);
    assign rsp_data    = (state_q == HOST_DONE) ? reply_q[39:8] : 32'h0;
    assign rsp_timeout = (state_q == HOST_DONE) && timeout_q;

`ifdef HRAM_UART_HOST_RSP_CHECK_EN
    logic check_fail;

    // Reply sanity check against the latched opcode/operand and the pad byte.
    always_comb begin
        check_fail = (reply_q[7:0] != PAD_BYTE);
        case (frame_q[47:40])
            OP_ADDR, OP_LOAD: if (reply_q[39:8] != frame_q[39:8]) check_fail = 1'b1;
            OP_WRITE:         if (reply_q[39:8] != WRITE_ACK)     check_fail = 1'b1;
            OP_READ_REQ:      if (reply_q[39:8] != READ_REQ_ACK)  check_fail = 1'b1;
            OP_CONST:         if (reply_q[39:8] != CONST_VALUE)   check_fail = 1'b1;
            default:          ;
        endcase
    end

    assign rsp_mismatch = (state_q == HOST_DONE) && check_fail;
`else
    assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_hram_uart_host.sv
// Scoreboard bench for hram_uart_host: a uart_tx model that drops ready two
// cycles after start, a directed responder on the rx side, and a monitor
// that checks each transmitted byte and each response against queues.
module tb_hram_uart_host;
    import hram_cmd_pkg::*;

`ifdef HRAM_UART_HOST_RSP_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        timeout;
        logic        mismatch;
        logic        chk_lat;
    } rsp_t;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        rsp_mismatch;
    logic        busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_rcv;
    logic [7:0]  rx_data;

    logic [7:0] txq[$];
    rsp_t       rspq[$];
    int compared    = 0;
    int mismatched  = 0;
    int cyc         = 0;
    int last_rx_cyc = 0;
    int tx_count    = 0;
    int tx_base     = 0;

    int         phase;
    int         hold_cnt;
    logic       cap_pulse;
    logic [7:0] cap_byte;

    hram_uart_host #(
        .TRAILER        (8'h0A),
        .TIMEOUT_CYCLES (100),
        .TO_W           (21)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_timeout  (rsp_timeout),
        .rsp_mismatch (rsp_mismatch),
        .busy         (busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .rx_rcv       (rx_rcv),
        .rx_data      (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx model: capture on start, drop ready 2 cycles later, busy a while.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_ready  <= 1'b1;
            phase     <= 0;
            hold_cnt  <= 0;
            cap_pulse <= 1'b0;
            cap_byte  <= 8'h00;
        end else begin
            cap_pulse <= 1'b0;
            case (phase)
                0: if (tx_start) begin
                    cap_pulse <= 1'b1;
                    cap_byte  <= tx_data;
                    tx_count  <= tx_count + 1;
                    phase     <= 1;
                end
                1: phase <= 2;
                2: begin
                    tx_ready <= 1'b0;
                    hold_cnt <= 5;
                    phase    <= 3;
                end
                default: begin
                    if (hold_cnt == 0) begin
                        tx_ready <= 1'b1;
                        phase    <= 0;
                    end else begin
                        hold_cnt <= hold_cnt - 1;
                    end
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: compare every captured tx byte and every response to the queues.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        rsp_t       exp_r;
        int         lat;
        if (cap_pulse) begin
            if (txq.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL tx_unexpected: got byte 0x%0h, expected none", cap_byte);
            end else begin
                exp_b = txq.pop_front();
                checkOutput("tx_byte", 64'(cap_byte), 64'(exp_b));
            end
        end
        if (rstn && rsp_valid) begin
            if (rspq.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL rsp_unexpected: got data 0x%0h, expected none", rsp_data);
            end else begin
                exp_r = rspq.pop_front();
                checkOutput("rsp_data", 64'(rsp_data), 64'(exp_r.data));
                checkOutput("rsp_timeout", 64'(rsp_timeout), 64'(exp_r.timeout));
                checkOutput("rsp_mismatch", 64'(rsp_mismatch), 64'(exp_r.mismatch));
                if (exp_r.chk_lat) begin
                    lat = cyc - last_rx_cyc;
                    checkOutput("timeout_latency", 64'(lat), (lat >= 98 && lat <= 106) ? 64'(lat) : 64'd102);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] data);
        int guard;
        txq.push_back(op);
        txq.push_back(data[31:24]);
        txq.push_back(data[23:16]);
        txq.push_back(data[15:8]);
        txq.push_back(data[7:0]);
        txq.push_back(8'h0A);
        @(negedge clk);
        guard = 0;
        while (!cmd_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        tx_base   = tx_count;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitTxFrame();
        int guard;
        guard = 0;
        while ((tx_count - tx_base) < 6 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        guard = 0;
        while (tx_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        guard = 0;
        while (!tx_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        checkOutput("tx_episodes", 64'(tx_count - tx_base), 64'd6);
    endtask

    task automatic sendReply(input logic [39:0] bytes, input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = bytes[39-8*i -: 8];
            @(negedge clk);
            rx_rcv      = 1'b1;
            rx_data     = b;
            last_rx_cyc = cyc;
            @(negedge clk);
            rx_rcv  = 1'b0;
            rx_data = 8'h00;
            @(negedge clk);
        end
    endtask

    task automatic expectRsp(input logic [31:0] data, input logic to, input logic mm, input logic lat);
        rsp_t r;
        r.data     = data;
        r.timeout  = to;
        r.mismatch = mm;
        r.chk_lat  = lat;
        rspq.push_back(r);
    endtask

    task automatic waitRsp();
        int guard;
        guard = 0;
        while (rspq.size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (rspq.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL rsp_wait: got no response, expected %0d pending", rspq.size());
            rspq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int guard;
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 8'h00;
        cmd_data  = 32'h0;
        rx_rcv    = 1'b0;
        rx_data   = 8'h00;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_tx_start", 64'(tx_start), 64'd0);
        checkOutput("rst_tx_data", 64'(tx_data), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_data", 64'(rsp_data), 64'd0);
        checkOutput("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        checkOutput("rst_rsp_mismatch", 64'(rsp_mismatch), 64'd0);

        $display("[TB] ADDR echo");
        applyStimulus(OP_ADDR, 32'h12345678);
        waitTxFrame();
        expectRsp(32'h12345678, 1'b0, 1'b0, 1'b0);
        sendReply(40'h12_34_56_78_00, 5);
        waitRsp();

        $display("[TB] CONST");
        applyStimulus(OP_CONST, 32'h0);
        waitTxFrame();
        expectRsp(32'd259, 1'b0, 1'b0, 1'b0);
        sendReply(40'h00_00_01_03_00, 5);
        waitRsp();

        $display("[TB] timeout after two bytes");
        applyStimulus(OP_READ, 32'h0);
        waitTxFrame();
        expectRsp(32'hABCD0000, 1'b1, 1'b0, 1'b1);
        sendReply(40'hAB_CD_00_00_00, 2);
        waitRsp();

        $display("[TB] WRITE with wrong ack");
        applyStimulus(OP_WRITE, 32'h00000010);
        waitTxFrame();
        expectRsp(32'd4, 1'b0, CHECK_EN, 1'b0);
        sendReply(40'h00_00_00_04_00, 5);
        waitRsp();

        $display("[TB] stray rx byte during transmit");
        applyStimulus(OP_READ, 32'h00000100);
        guard = 0;
        while (!tx_start && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        rx_rcv  = 1'b1;
        rx_data = 8'hFF;
        @(negedge clk);
        rx_rcv  = 1'b0;
        rx_data = 8'h00;
        waitTxFrame();
        expectRsp(32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        sendReply(40'hDE_AD_BE_EF_00, 5);
        waitRsp();

        $display("[TB] reset mid-frame");
        applyStimulus(OP_COUNT, 32'hCAFEF00D);
        guard = 0;
        while ((tx_count - tx_base) < 3 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checkOutput("abort_tx_start", 64'(tx_start), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("abort_bytes_left", 64'(txq.size()), 64'd3);
        txq.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        $display("[TB] COUNT after abort");
        applyStimulus(OP_COUNT, 32'h00000001);
        waitTxFrame();
        expectRsp(32'h0000002A, 1'b0, 1'b0, 1'b0);
        sendReply(40'h00_00_00_2A_00, 5);
        waitRsp();

        repeat (5) @(negedge clk);
        checkOutput("txq_drained", 64'(txq.size()), 64'd0);
        checkOutput("rspq_drained", 64'(rspq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Watchdog so a stuck handshake still ends the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
